// File: rtl/fir_sample_loader_if.sv
// Bundled control, sample stream, memory write and FIR handoff signals of fir_sample_loader.
// master is the loader side; slave is the surrounding system (stream source, memory, FIR).
interface fir_sample_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) ();
  logic              cfg_go;
  logic [ADDR_W-1:0] cfg_input_addr;
  logic [ADDR_W-1:0] cfg_output_addr;
  logic [ADDR_W-1:0] cfg_sample_count;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic              fir_start;
  logic [ADDR_W-1:0] fir_input_addr;
  logic [ADDR_W-1:0] fir_output_addr;
  logic [ADDR_W-1:0] fir_sample_count;
  logic              fir_done;
  logic              busy;
  logic              complete;
  logic              err;

  modport master (
    input  cfg_go, cfg_input_addr, cfg_output_addr, cfg_sample_count,
    input  s_valid, s_data, fir_done,
    output s_ready, mem_addr, mem_data, mem_we,
    output fir_start, fir_input_addr, fir_output_addr, fir_sample_count,
    output busy, complete, err
  );

  modport slave (
    output cfg_go, cfg_input_addr, cfg_output_addr, cfg_sample_count,
    output s_valid, s_data, fir_done,
    input  s_ready, mem_addr, mem_data, mem_we,
    input  fir_start, fir_input_addr, fir_output_addr, fir_sample_count,
    input  busy, complete, err
  );
endinterface

// File: rtl/fir_sample_loader.sv
// Streams samples into the shared sample memory, then kicks the FIR and waits for its done edge.
// Optional FIR_LOADER_TIMEOUT_EN adds a WAIT_FIR watchdog of TIMEOUT_CYCLES that aborts with err.
module fir_sample_loader #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                 clk,
  input logic                 rst,
  fir_sample_loader_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_KICK, S_WAIT, S_FINISH
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_input_addr;
  logic [ADDR_W-1:0] r_output_addr;
  logic [ADDR_W-1:0] r_sample_count;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_mem_we;
  logic              r_err;
  logic              r_done_q;
  logic [ADDR_W:0]   w_end_addr;
  logic              w_cfg_ok;
  logic              w_go;
  logic              w_beat;
  logic              w_last_beat;
  logic              w_done_rise;
  logic              w_timeout;
  logic              w_s_ready;
  logic              w_fir_start;
  logic              w_busy;
  logic              w_complete;

  // Extra bit so a job ending exactly at the top of memory is accepted but one past it is not.
  assign w_end_addr  = {1'b0, bus.cfg_input_addr} + {1'b0, bus.cfg_sample_count};
  assign w_cfg_ok    = (bus.cfg_sample_count != '0) && (w_end_addr <= {1'b1, {ADDR_W{1'b0}}});
  assign w_go        = (r_state == S_IDLE) && bus.cfg_go;
  assign w_beat      = (r_state == S_LOAD) && bus.s_valid;
  assign w_last_beat = w_beat && (r_count == r_sample_count - ADDR_W'(1));
  assign w_done_rise = bus.fir_done & ~r_done_q;

`ifdef FIR_LOADER_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] r_timer;

  always_ff @(posedge clk) begin
    if (rst || (r_state != S_WAIT)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !w_done_rise &&
                     (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_go && w_cfg_ok) w_state_next = S_LOAD;
      S_LOAD:   if (w_last_beat) w_state_next = S_DRAIN;
      S_DRAIN:  w_state_next = S_KICK;
      S_KICK:   w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_done_rise) begin
          w_state_next = S_FINISH;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
        end
      end
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_s_ready   = 1'b0;
    w_fir_start = 1'b0;
    w_complete  = 1'b0;
    w_busy      = (r_state != S_IDLE);
    case (r_state)
      S_LOAD:   w_s_ready   = 1'b1;
      S_KICK:   w_fir_start = 1'b1;
      S_FINISH: w_complete  = 1'b1;
      default:  ;
    endcase
  end

  // Config is latched on every accepted cfg_go, including rejected jobs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_input_addr   <= '0;
      r_output_addr  <= '0;
      r_sample_count <= '0;
      r_count        <= '0;
      r_mem_addr     <= '0;
      r_mem_data     <= '0;
      r_mem_we       <= 1'b0;
      r_err          <= 1'b0;
      r_done_q       <= 1'b0;
    end else begin
      r_done_q <= bus.fir_done;
      r_mem_we <= w_beat;
      r_err    <= w_timeout;
      if (w_beat) begin
        r_mem_addr <= r_input_addr + r_count;
        r_mem_data <= bus.s_data;
        r_count    <= r_count + ADDR_W'(1);
      end
      if (w_go) begin
        r_input_addr   <= bus.cfg_input_addr;
        r_output_addr  <= bus.cfg_output_addr;
        r_sample_count <= bus.cfg_sample_count;
        r_count        <= '0;
        r_err          <= !w_cfg_ok;
      end
    end
  end

  assign bus.s_ready          = w_s_ready;
  assign bus.mem_addr         = r_mem_addr;
  assign bus.mem_data         = r_mem_data;
  assign bus.mem_we           = r_mem_we;
  assign bus.fir_start        = w_fir_start;
  assign bus.fir_input_addr   = r_input_addr;
  assign bus.fir_output_addr  = r_output_addr;
  assign bus.fir_sample_count = r_sample_count;
  assign bus.busy             = w_busy;
  assign bus.complete         = w_complete;
  assign bus.err              = r_err;
endmodule

// File: tb/tb_fir_sample_loader.sv
// Self-checking bench for fir_sample_loader: write scoreboard plus per-scenario timing checks.
// The timeout scenario runs only when FIR_LOADER_TIMEOUT_EN is defined.
module tb_fir_sample_loader;
  localparam int AW = 10;
  localparam int DW = 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_sample_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fir_sample_loader #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  wr_t exp_q[$];
  int  start_cnt = 0, start_cyc = 0;
  int  complete_cnt = 0, complete_cyc = 0;
  int  err_cnt = 0, err_cyc = 0;
  int  beat_cnt = 0, wr_cnt = 0;
  int  hs_cyc = 0, rise_cyc = 0;
  logic [AW-1:0] last_wr_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one line per memory write, scoreboard comparison, event bookkeeping.
  always @(negedge clk) begin
    wr_t w;
    if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) beat_cnt++;
    if (bus.fir_start === 1'b1) begin start_cnt++; start_cyc = cyc; end
    if (bus.complete === 1'b1) begin complete_cnt++; complete_cyc = cyc; end
    if (bus.err === 1'b1) begin err_cnt++; err_cyc = cyc; end
    if (bus.mem_we === 1'b1) begin
      wr_cnt++;
      last_wr_addr = bus.mem_addr;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mem_write unexpected: got addr=%03h data=%02h, required no write", bus.mem_addr, bus.mem_data);
      end else begin
        w = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_data} !== w) begin
          errors++;
          $display("FAIL mem_write: got addr=%03h data=%02h, required addr=%03h data=%02h", bus.mem_addr, bus.mem_data, w.a, w.d);
        end else begin
          $display("write addr=%03h data=%02h ok", bus.mem_addr, bus.mem_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] ia, input logic [AW-1:0] oa, input logic [AW-1:0] cnt);
    bus.cfg_input_addr   = ia;
    bus.cfg_output_addr  = oa;
    bus.cfg_sample_count = cnt;
    bus.cfg_go           = 1'b1;
    tick();
    bus.cfg_go           = 1'b0;
  endtask

  // Drives n beats with data (i+1)*0x11+seed; pushes the expected write when a beat is accepted.
  task automatic stream(input logic [AW-1:0] base, input int n, input logic [DW-1:0] seed,
                        input bit gaps, output bit ok);
    int budget;
    logic [DW-1:0] d;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin bus.s_valid = 1'b0; tick(); end
      d = DW'((i + 1) * 17) + seed;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      budget = 0;
      @(negedge clk);
      while (bus.s_ready !== 1'b1 && budget < 20) begin @(negedge clk); budget++; end
      if (bus.s_ready !== 1'b1) begin ok = 1'b0; bus.s_valid = 1'b0; return; end
      exp_q.push_back({base + AW'(i), d});
      hs_cyc = cyc;
      tick();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_start(input int n0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (start_cnt != n0) ok = 1'b1;
      else begin @(negedge clk); #1; end
    end
  endtask

  task automatic wait_complete(input int n0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (complete_cnt != n0) ok = 1'b1;
      else begin @(negedge clk); #1; end
    end
  endtask

  task automatic pulse_done();
    bus.fir_done = 1'b0;
    tick();
    bus.fir_done = 1'b1;
    rise_cyc = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({bus.s_ready, bus.mem_we, bus.fir_start, bus.complete, bus.err, bus.busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 000000", {bus.s_ready, bus.mem_we, bus.fir_start, bus.complete, bus.err, bus.busy});
    end
    checks++;
    if ({bus.fir_input_addr, bus.fir_output_addr, bus.fir_sample_count} !== '0) begin
      errors++;
      $display("FAIL reset_fir_bus: got %h %h %h, required 0 0 0", bus.fir_input_addr, bus.fir_output_addr, bus.fir_sample_count);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_data} !== '0) begin
      errors++;
      $display("FAIL reset_mem_bus: got %h %h, required 0 0", bus.mem_addr, bus.mem_data);
    end
    tick();
    rst = 1'b0;
    tick();
    $display("reset checked");
  endtask

  task automatic test_basic_load();
    bit ok;
    int s0 = start_cnt, c0 = complete_cnt, w0 = wr_cnt;
    start_job(10'h010, 10'h200, 10'd4);
    checks++;
    if (bus.busy !== 1'b1 || bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_enter_load: got busy=%b s_ready=%b, required 1 1", bus.busy, bus.s_ready);
    end
    stream(10'h010, 4, 8'h00, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_stream: got stalled, required 4 beats"); end
    wait_start(s0, ok);
    checks++;
    if (!ok || start_cyc != hs_cyc + 2) begin
      errors++;
      $display("FAIL basic_start_latency: got %0d cycles (seen=%0d), required 2", start_cyc - hs_cyc, ok);
    end
    checks++;
    if ({bus.fir_input_addr, bus.fir_output_addr, bus.fir_sample_count} !== {10'h010, 10'h200, 10'd4}) begin
      errors++;
      $display("FAIL basic_fir_bus: got %h %h %h, required 010 200 004", bus.fir_input_addr, bus.fir_output_addr, bus.fir_sample_count);
    end
    repeat (3) tick();
    checks++;
    if (wr_cnt - w0 != 4 || exp_q.size() != 0 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL basic_counts: got writes=%0d pending=%0d starts=%0d, required 4 0 1", wr_cnt - w0, exp_q.size(), start_cnt - s0);
    end
    pulse_done();
    wait_complete(c0, ok);
    checks++;
    if (!ok || complete_cyc != rise_cyc + 1) begin
      errors++;
      $display("FAIL basic_complete: got delay=%0d seen=%0d, required delay 1", complete_cyc - rise_cyc, ok);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || complete_cnt - c0 != 1) begin
      errors++;
      $display("FAIL basic_idle: got busy=%b completes=%0d, required 0 1", bus.busy, complete_cnt - c0);
    end
    tick();
    $display("basic load done");
  endtask

  task automatic test_backpressure();
    bit ok;
    int s0 = start_cnt, c0 = complete_cnt, w0 = wr_cnt, b0 = beat_cnt;
    start_job(10'h010, 10'h200, 10'd4);
    bus.cfg_input_addr = 10'h2AA;
    bus.cfg_go = 1'b1;
    tick();
    bus.cfg_go = 1'b0;
    stream(10'h010, 4, 8'h50, 1'b1, ok);
    bus.s_valid = 1'b1;
    repeat (4) tick();
    bus.s_valid = 1'b0;
    wait_start(s0, ok);
    checks++;
    if (!ok || start_cyc != hs_cyc + 2) begin
      errors++;
      $display("FAIL bp_start_latency: got %0d (seen=%0d), required 2", start_cyc - hs_cyc, ok);
    end
    checks++;
    if (beat_cnt - b0 != 4 || wr_cnt - w0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_beats: got beats=%0d writes=%0d pending=%0d, required 4 4 0", beat_cnt - b0, wr_cnt - w0, exp_q.size());
    end
    checks++;
    if (bus.fir_input_addr !== 10'h010) begin
      errors++;
      $display("FAIL bp_go_ignored: got fir_input_addr=%h, required 010", bus.fir_input_addr);
    end
    repeat (6) tick();
    checks++;
    if (complete_cnt != c0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_stale_level: got completes=%0d busy=%b, required 0 1", complete_cnt - c0, bus.busy);
    end
    pulse_done();
    wait_complete(c0, ok);
    checks++;
    if (!ok || complete_cyc != rise_cyc + 1) begin
      errors++;
      $display("FAIL bp_complete: got delay=%0d seen=%0d, required 1", complete_cyc - rise_cyc, ok);
    end
    tick();
    $display("backpressure done");
  endtask

  task automatic test_stale_done();
    bit ok;
    int s0 = start_cnt, c0 = complete_cnt;
    bus.fir_done = 1'b1;
    start_job(10'h040, 10'h210, 10'd3);
    stream(10'h040, 3, 8'h80, 1'b0, ok);
    wait_start(s0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stale_start: got no fir_start, required one"); end
    tick();
    bus.fir_done = 1'b0;
    repeat (10) tick();
    checks++;
    if (complete_cnt != c0) begin
      errors++;
      $display("FAIL stale_early_complete: got %0d completes, required 0", complete_cnt - c0);
    end
    bus.fir_done = 1'b1;
    rise_cyc = cyc;
    wait_complete(c0, ok);
    checks++;
    if (!ok || complete_cyc != rise_cyc + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stale_complete: got delay=%0d seen=%0d pending=%0d, required 1 1 0", complete_cyc - rise_cyc, ok, exp_q.size());
    end
    tick();
    $display("stale done checked");
  endtask

  task automatic test_reject();
    logic [AW-1:0] ra[2] = '{10'h100, 10'h3FE};
    logic [AW-1:0] rc[2] = '{10'd0, 10'd4};
    bit ok;
    bit busy_seen;
    int e0, w0, g, s0, c0;
    for (int k = 0; k < 2; k++) begin
      e0 = err_cnt; w0 = wr_cnt; busy_seen = 1'b0;
      start_job(ra[k], 10'h300, rc[k]);
      g = cyc;
      for (int i = 0; i < 4; i++) begin @(negedge clk); busy_seen |= (bus.busy !== 1'b0); end
      tick();
      checks++;
      if (err_cnt - e0 != 1 || err_cyc != g || wr_cnt != w0 || busy_seen) begin
        errors++;
        $display("FAIL reject_%0d: got errs=%0d err_at=%0d writes=%0d busy=%b, required 1 %0d 0 0", k, err_cnt - e0, err_cyc, wr_cnt - w0, busy_seen, g);
      end
      checks++;
      if (bus.fir_sample_count !== rc[k] || bus.fir_input_addr !== ra[k]) begin
        errors++;
        $display("FAIL reject_latch_%0d: got %h %h, required %h %h", k, bus.fir_input_addr, bus.fir_sample_count, ra[k], rc[k]);
      end
    end
    s0 = start_cnt; c0 = complete_cnt; e0 = err_cnt;
    start_job(10'h3FC, 10'h000, 10'd4);
    stream(10'h3FC, 4, 8'h20, 1'b0, ok);
    wait_start(s0, ok);
    repeat (2) tick();
    checks++;
    if (!ok || last_wr_addr !== 10'h3FF || exp_q.size() != 0 || err_cnt != e0) begin
      errors++;
      $display("FAIL top_of_mem: got start=%0d last=%h pending=%0d errs=%0d, required 1 3ff 0 0", ok, last_wr_addr, exp_q.size(), err_cnt - e0);
    end
    pulse_done();
    wait_complete(c0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL top_of_mem_complete: got none, required one"); end
    tick();
    $display("rejections checked");
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    int s0, c0;
    s0 = start_cnt;
    start_job(10'h100, 10'h300, 10'd4);
    stream(10'h100, 2, 8'h90, 1'b0, ok);
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.s_ready, bus.mem_we, bus.busy} !== 3'b000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset: got s_ready/mem_we/busy=%b pending=%0d, required 000 0", {bus.s_ready, bus.mem_we, bus.busy}, exp_q.size());
    end
    tick();
    rst = 1'b0;
    bus.fir_done = 1'b0;
    repeat (3) tick();
    checks++;
    if (start_cnt != s0) begin
      errors++;
      $display("FAIL midreset_start: got %0d starts, required 0", start_cnt - s0);
    end
    c0 = complete_cnt;
    start_job(10'h020, 10'h310, 10'd2);
    stream(10'h020, 2, 8'hA0, 1'b0, ok);
    wait_start(s0, ok);
    checks++;
    if (!ok || start_cyc != hs_cyc + 2) begin
      errors++;
      $display("FAIL midreset_rerun_start: got %0d (seen=%0d), required 2", start_cyc - hs_cyc, ok);
    end
    pulse_done();
    wait_complete(c0, ok);
    checks++;
    if (!ok || exp_q.size() != 0 || complete_cyc != rise_cyc + 1) begin
      errors++;
      $display("FAIL midreset_rerun_complete: got seen=%0d pending=%0d delay=%0d, required 1 0 1", ok, exp_q.size(), complete_cyc - rise_cyc);
    end
    tick();
    $display("reset mid-load checked");
  endtask

`ifdef FIR_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int s0 = start_cnt, c0 = complete_cnt, e0 = err_cnt;
    bus.fir_done = 1'b0;
    tick();
    start_job(10'h050, 10'h320, 10'd1);
    stream(10'h050, 1, 8'h05, 1'b0, ok);
    wait_start(s0, ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (err_cnt != e0) ok = 1'b1;
      else begin @(negedge clk); #1; end
    end
    checks++;
    if (!ok || err_cyc != start_cyc + 17 || complete_cnt != c0) begin
      errors++;
      $display("FAIL timeout: got seen=%0d delay=%0d completes=%0d, required 1 17 0", ok, err_cyc - start_cyc, complete_cnt - c0);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b, required 0", bus.busy);
    end
    tick();
    $display("timeout checked");
  endtask
`endif

  initial begin
    bus.cfg_go = 1'b0;
    bus.cfg_input_addr = '0;
    bus.cfg_output_addr = '0;
    bus.cfg_sample_count = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.fir_done = 1'b0;
    test_reset();
    test_basic_load();
    test_backpressure();
    test_stale_done();
    test_reject();
    test_reset_mid_load();
`ifdef FIR_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
